// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// immediate selection for operand b, and load-use bubble insertion.
module idex_operand_stage #(
  parameter int         XLEN     = 64,
  parameter logic [4:0] ZERO_REG = 5'd31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [4:0]      id_rn,
  input  logic [4:0]      id_rm,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_readData1,
  input  logic [XLEN-1:0] id_readData2,
  input  logic [XLEN-1:0] id_signImm,
  input  logic            id_ALUSrc,
  input  logic [3:0]      id_ALUControl,
  input  logic            id_regWrite,
  input  logic            id_memRead,
  input  logic            id_memWrite,
  input  logic            id_memtoReg,
  input  logic            id_branch,
  input  logic            hold,
  input  logic            flush,
  input  logic            exmem_regWrite,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_aluResult,
  input  logic            memwb_regWrite,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_writeData,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      ex_ALUControl,
  output logic [XLEN-1:0] ex_storeData,
  output logic [XLEN-1:0] ex_signImm,
  output logic [4:0]      ex_rd,
  output logic            ex_valid,
  output logic            ex_regWrite,
  output logic            ex_memRead,
  output logic            ex_memWrite,
  output logic            ex_memtoReg,
  output logic            ex_branch,
  output logic            load_use_stall
);

  typedef struct packed {
    logic            valid;
    logic [4:0]      rn;
    logic [4:0]      rm;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic            alusrc;
    logic [3:0]      aluctrl;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            branch;
  } stage_t;

  stage_t          stage_q;
  stage_t          stage_d;
  logic            lus_s;
  logic [XLEN-1:0] fwd_a_s;
  logic [XLEN-1:0] fwd_b_s;

  // EX/MEM beats MEM/WB; XZR is never a forward target.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      src,
    input logic [XLEN-1:0] reg_val,
    input logic            em_we,
    input logic [4:0]      em_rd,
    input logic [XLEN-1:0] em_val,
    input logic            mw_we,
    input logic [4:0]      mw_rd,
    input logic [XLEN-1:0] mw_val
  );
    logic [XLEN-1:0] res;
    if (em_we && (em_rd == src) && (src != ZERO_REG)) begin
      res = em_val;
    end else if (mw_we && (mw_rd == src) && (src != ZERO_REG)) begin
      res = mw_val;
    end else begin
      res = reg_val;
    end
    return res;
  endfunction

  always_comb begin
    lus_s = 1'b0;
    if (!flush && stage_q.valid && stage_q.memread && (stage_q.rd != ZERO_REG) &&
        id_valid && ((stage_q.rd == id_rn) || (stage_q.rd == id_rm))) begin
      lus_s = 1'b1;
    end else begin
      lus_s = 1'b0;
    end
  end

  always_comb begin
    fwd_a_s = fwd_sel(stage_q.rn, stage_q.rd1, exmem_regWrite, exmem_rd, exmem_aluResult,
                      memwb_regWrite, memwb_rd, memwb_writeData);
    fwd_b_s = fwd_sel(stage_q.rm, stage_q.rd2, exmem_regWrite, exmem_rd, exmem_aluResult,
                      memwb_regWrite, memwb_rd, memwb_writeData);
  end

  // Next-state priority: flush, hold, load-use bubble, capture.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (hold) begin
      stage_d = stage_q;
    end else if (lus_s) begin
      stage_d = '0;
    end else begin
      stage_d.valid    = id_valid;
      stage_d.rn       = id_rn;
      stage_d.rm       = id_rm;
      stage_d.rd       = id_rd;
      stage_d.rd1      = id_readData1;
      stage_d.rd2      = id_readData2;
      stage_d.imm      = id_signImm;
      stage_d.alusrc   = id_ALUSrc;
      stage_d.aluctrl  = id_ALUControl;
      stage_d.regwrite = id_valid & id_regWrite;
      stage_d.memread  = id_valid & id_memRead;
      stage_d.memwrite = id_valid & id_memWrite;
      stage_d.memtoreg = id_valid & id_memtoReg;
      stage_d.branch   = id_valid & id_branch;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign alu_a          = fwd_a_s;
  assign alu_b          = stage_q.alusrc ? stage_q.imm : fwd_b_s;
  assign ex_storeData   = fwd_b_s;
  assign ex_signImm     = stage_q.imm;
  assign ex_ALUControl  = stage_q.aluctrl;
  assign ex_rd          = stage_q.rd;
  assign ex_valid       = stage_q.valid;
  assign ex_regWrite    = stage_q.regwrite;
  assign ex_memRead     = stage_q.memread;
  assign ex_memWrite    = stage_q.memwrite;
  assign ex_memtoReg    = stage_q.memtoreg;
  assign ex_branch      = stage_q.branch;
  assign load_use_stall = lus_s;

endmodule

// File: doc/idex_operand_stage.md
# idex_operand_stage

ID/EX pipeline register and operand-forwarding stage for the 64-bit pipelined processor. It sits between decode and the ALU. It registers the decoded operands and control bits each cycle. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and selects register or immediate for the second ALU operand. It also detects load-use hazards and inserts the required bubble.

## Interface
Parameters:
- `XLEN`, 64: datapath width.
- `ZERO_REG`, 31: index of XZR; never forwarded, never a hazard source.

Ports (clock and reset first):
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state.
- `id_valid`  in  1: decode stage holds a real instruction.
- `id_rn`, `id_rm`, `id_rd`  in  5 each: source and destination register indices.
- `id_readData1`, `id_readData2`  in  XLEN each: register file read values for rn and rm.
- `id_signImm`  in  XLEN: sign-extended immediate.
- `id_ALUSrc`  in  1: 1 selects the immediate as ALU operand b.
- `id_ALUControl`  in  4: ALU operation code.
- `id_regWrite`, `id_memRead`, `id_memWrite`, `id_memtoReg`, `id_branch`  in  1 each: control bits.
- `hold`  in  1: freeze the stage (external memory wait).
- `flush`  in  1: squash the stage (taken branch).
- `exmem_regWrite`  in  1, `exmem_rd`  in  5, `exmem_aluResult`  in  XLEN: EX/MEM forward source.
- `memwb_regWrite`  in  1, `memwb_rd`  in  5, `memwb_writeData`  in  XLEN: MEM/WB forward source.
- `alu_a`, `alu_b`  out  XLEN: ALU operands.
- `ex_ALUControl`  out  4: registered ALU operation code.
- `ex_storeData`  out  XLEN: forwarded rm value, used as store data.
- `ex_signImm`  out  XLEN: registered immediate, used for the branch target.
- `ex_rd`  out  5: registered destination index.
- `ex_valid`, `ex_regWrite`, `ex_memRead`, `ex_memWrite`, `ex_memtoReg`, `ex_branch`  out  1 each: registered valid and control bits.
- `load_use_stall`  out  1: request to IF/ID to hold the current instruction.

## Operation
- Register update priority each rising edge: `flush`, then `hold`, then `load_use_stall`, then capture.
- `flush`=1: load a bubble.
- `hold`=1 (and no flush): keep all registered fields unchanged.
- `load_use_stall`=1 (and no flush or hold): load a bubble.
- Otherwise: capture every `id_*` field; `ex_valid` becomes `id_valid`.
- Bubble: `ex_valid`, all control bits, `ex_ALUControl`, `ex_rd` and all data fields are cleared to 0.
- If `id_valid`=0, data is still captured, but all control bits are registered as 0.
- Forwarding for operand A is combinational and uses the registered rn:
  - Use EX/MEM when `exmem_regWrite`=1, `exmem_rd`==rn and rn!=ZERO_REG.
  - Otherwise use MEM/WB when `memwb_regWrite`=1, `memwb_rd`==rn and rn!=ZERO_REG.
  - Otherwise use the registered readData1.
  - EX/MEM takes priority over MEM/WB.
- Forwarding for the rm value uses the same rules with rm and readData2.
- `alu_b` = `ex_ALUSrc` ? `ex_signImm` : forwarded rm value.
- `ex_storeData` = forwarded rm value, regardless of ALUSrc.
- `load_use_stall` is combinational: `ex_valid` & `ex_memRead` & (`ex_rd`!=ZERO_REG) & `id_valid` & (`ex_rd`==`id_rn` | `ex_rd`==`id_rm`).
- `load_use_stall` is forced to 0 while `flush`=1.

## Timing
- Reset (`reset`=0, asynchronous): every registered field is 0, so `ex_valid`=0 and all control outputs are 0. `alu_a`, `alu_b`, `ex_storeData` and `load_use_stall` read 0 unless a forward source is active.
- Reset asserted mid-operation clears the stage immediately; it does not wait for an edge.
- Latency: ID values appear on `ex_*` outputs one cycle after the capturing edge.
- Forwarded values appear in the same cycle the EX/MEM or MEM/WB inputs change; no extra cycle.
- A load-use hazard costs exactly one bubble. On the next edge the load has moved to MEM, `load_use_stall` drops, and the dependent instruction then gets its value via MEM/WB forwarding.
- `hold` together with a load-use condition: the stage holds; `load_use_stall` stays asserted.
- `flush` together with `hold`: flush wins and a bubble is loaded.

## Test plan
- Reset: `reset`=0 mid-run → all `ex_*`=0, `ex_valid`=0 without a clock edge. Release with `id_valid`=1, rn=1, readData1=5 → next cycle `alu_a`=5.
- EX/MEM priority: rn=3; `exmem_rd`=3 with aluResult=0xAA; `memwb_rd`=3 with writeData=0xBB; both regWrite=1 → `alu_a`=0xAA. Drop `exmem_regWrite` → `alu_a`=0xBB.
- XZR: rm=31, `exmem_rd`=31, `exmem_regWrite`=1, readData2=0 → `ex_storeData`=0.
- Immediate select: ALUSrc=1, signImm=−8 → `alu_b`=0xFFFF_FFFF_FFFF_FFF8.
- Load-use: LDUR X2 in EX, decode holds ADD X4,X2,X5 → `load_use_stall`=1 for one cycle and a bubble is loaded (`ex_valid`=0). On the next edge the ADD is captured; `alu_a` takes the MEM/WB value 0x1234.
- Flush and hold together: `flush`=1 and `hold`=1 with a valid instruction in the stage → next cycle `ex_valid`=0 and `ex_regWrite`=0. Then `hold`=1 alone for 3 cycles → outputs remain unchanged.
